// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-digit common-anode
// 7-segment display. Once per frame it takes a tear-free snapshot of the eight
// display codes. It then scans the digits left to right, decodes each
// character to segments, and keeps all anodes dark for the first few clocks of
// every digit slot so that the previous digit does not ghost into the next.
module seg7_scan_driver #(
    parameter int CLOCK_FREQ   = 100_000_000,
    parameter int DIGIT_HZ     = 1_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_start
);

    localparam int DIV = CLOCK_FREQ / DIGIT_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
    localparam logic [5:0]    CODE_OFF  = 6'b100000;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [5:0]    r_snap [8];
    logic [7:0]    r_an;
    logic [7:0]    r_seg;
    logic          r_frame_start;

    logic          w_frame_pos0;
    logic [5:0]    w_code;
    logic [7:0]    w_an_next;
    logic [7:0]    w_seg_next;
    logic [5:0]    w_din [8];

    // d1 is the leftmost digit, so it lands in slot 0 and drives an[7].
    assign w_din[0] = d1;
    assign w_din[1] = d2;
    assign w_din[2] = d3;
    assign w_din[3] = d4;
    assign w_din[4] = d5;
    assign w_din[5] = d6;
    assign w_din[6] = d7;
    assign w_din[7] = d8;

    assign w_frame_pos0 = (r_idx == 3'd0) && (r_cnt == '0);

    // Character code to active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] ch);
        case (ch)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;  // A
            4'hB:    glyph = 7'h61;  // J
            4'hC:    glyph = 7'h41;  // U
            4'hD:    glyph = 7'h0C;  // P
            4'hE:    glyph = 7'h06;  // E
            default: glyph = 7'h0E;  // F
        endcase
    endfunction

    // Next anode/segment pattern from the current slot position and snapshot.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        w_an_next  = 8'hFF;
        w_seg_next = 8'hFF;
        w_code     = r_snap[r_idx];
        if (r_cnt >= BLANK_LIM && !w_code[5]) begin
            w_an_next  = ~(8'h80 >> r_idx);
            w_seg_next = {~w_code[0], glyph(w_code[4:1])};
        end
    end

    // Digit-slot counter and digit index; both wrap naturally.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Frame snapshot: capture all eight codes at the start of slot 0.
    always_ff @(posedge clock) begin
        // NOTE: only eight small registers, so an explicit reset is cheap and keeps the display dark.
        if (!reset) begin
            for (int k = 0; k < 8; k++) r_snap[k] <= CODE_OFF;
        end else if (w_frame_pos0) begin
            for (int k = 0; k < 8; k++) r_snap[k] <= w_din[k];
        end
    end

    // Registered pin drivers; they lag the counter state by one clock.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_an          <= 8'hFF;
            r_seg         <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            r_an          <= w_an_next;
            r_seg         <= w_seg_next;
            r_frame_start <= w_frame_pos0;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign frame_start = r_frame_start;

endmodule
